// File: rtl/control_sequencer.sv
// Micro-instruction sequencer for DataPath: accepts opcode+immediate over valid/ready
// and expands each instruction into one or two registered register-transfer steps.

module control_sequencer_checker #(
  parameter int IMM_W = 8
) (
  input logic             clock,
  input logic             clear,
  input logic             RAin,
  input logic             RBin,
  input logic             RZin,
  input logic             RAout,
  input logic             RBout,
  input logic             RZout,
  input logic             busy,
  input logic             done,
  input logic             illegal,
  input logic [IMM_W-1:0] AddImmediate,
  input logic [IMM_W-1:0] RegisterAImmediate
);

  a_single_driver: assert property (@(posedge clock) disable iff (clear)
    $onehot0({RAout, RBout, RZout}))
    else $error("more than one DataPath register driving the bus");

  a_no_self_transfer: assert property (@(posedge clock) disable iff (clear)
    !((RAin && RAout) || (RBin && RBout) || (RZin && RZout)))
    else $error("register both driven and loaded in the same cycle");

  a_done_xor_illegal: assert property (@(posedge clock) disable iff (clear)
    !(done && illegal))
    else $error("done and illegal asserted together");

  // Outside a step every strobe and both buses must be quiet.
  a_idle_quiet: assert property (@(posedge clock) disable iff (clear)
    !busy |-> ({RAin, RBin, RZin, RAout, RBout, RZout, done, illegal} == 8'b0000_0000 &&
               AddImmediate == {IMM_W{1'b0}} && RegisterAImmediate == {IMM_W{1'b0}}))
    else $error("outputs active while idle");

endmodule

module control_sequencer #(
  parameter int IMM_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       instr_op,
  input  logic [IMM_W-1:0] instr_imm,
  output logic             RAin,
  output logic             RBin,
  output logic             RZin,
  output logic             RAout,
  output logic             RBout,
  output logic             RZout,
  output logic [IMM_W-1:0] AddImmediate,
  output logic [IMM_W-1:0] RegisterAImmediate,
  output logic             busy,
  output logic             done,
  output logic             illegal,
  output logic [CNT_W-1:0] retired_count
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_T0   = 2'd1;
  localparam logic [1:0] ST_T1   = 2'd2;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LDIA  = 3'b001;
  localparam logic [2:0] OP_ADDIB = 3'b010;
  localparam logic [2:0] OP_ADDIA = 3'b011;
  localparam logic [2:0] OP_MVZB  = 3'b100;
  localparam logic [2:0] OP_MVZA  = 3'b101;

  logic [1:0]       state_r;
  logic [2:0]       op_r;
  logic [IMM_W-1:0] imm_r;
  logic             final_r;

  logic [1:0]       state_s;
  logic [2:0]       op_s;
  logic [IMM_W-1:0] imm_s;
  logic             final_s;
  logic             accept_s;
  logic             retire_s;
  logic [7:0]       strobe_s;
  logic [IMM_W-1:0] add_imm_s;
  logic [IMM_W-1:0] rega_imm_s;

  function automatic logic is_two_step(input logic [2:0] op);
    return (op == OP_ADDIB) || (op == OP_ADDIA);
  endfunction

  function automatic logic is_legal(input logic [2:0] op);
    logic legal;
    case (op)
      OP_NOP, OP_LDIA, OP_ADDIB, OP_ADDIA, OP_MVZB, OP_MVZA: legal = 1'b1;
      default:                                                legal = 1'b0;
    endcase
    return legal;
  endfunction

  // Bit order: {RAin, RBin, RZin, RAout, RBout, RZout, done, illegal}.
  function automatic logic [7:0] step_strobes(input logic [2:0] op, input logic second);
    logic [7:0] s;
    case (op)
      OP_NOP:   s = 8'b0000_0010;
      OP_LDIA:  s = 8'b1000_0010;
      OP_ADDIB: s = second ? 8'b0100_0110 : 8'b0011_0000;
      OP_ADDIA: s = second ? 8'b1000_0110 : 8'b0011_0000;
      OP_MVZB:  s = 8'b0100_0110;
      OP_MVZA:  s = 8'b1000_0110;
      default:  s = 8'b0000_0001;
    endcase
    return s;
  endfunction

  assign instr_ready = (state_r == ST_IDLE) || final_r;
  assign accept_s    = instr_valid && instr_ready;
  assign retire_s    = (state_r != ST_IDLE) && final_r && is_legal(op_r);

  // Next step selection; a new instruction always wins over IDLE at a final step.
  always_comb begin
    state_s = ST_IDLE;
    op_s    = op_r;
    imm_s   = imm_r;
    if (accept_s) begin
      state_s = ST_T0;
      op_s    = instr_op;
      imm_s   = instr_imm;
    end else if ((state_r == ST_T0) && !final_r) begin
      state_s = ST_T1;
    end else begin
      state_s = ST_IDLE;
    end
  end

  // Decode the step about to execute so every output can be registered.
  always_comb begin
    final_s    = 1'b0;
    strobe_s   = 8'b0000_0000;
    add_imm_s  = {IMM_W{1'b0}};
    rega_imm_s = {IMM_W{1'b0}};
    case (state_s)
      ST_T0: begin
        final_s    = !is_two_step(op_s);
        strobe_s   = step_strobes(op_s, 1'b0);
        add_imm_s  = is_two_step(op_s) ? imm_s : {IMM_W{1'b0}};
        rega_imm_s = (op_s == OP_LDIA) ? imm_s : {IMM_W{1'b0}};
      end
      ST_T1: begin
        final_s  = 1'b1;
        strobe_s = step_strobes(op_s, 1'b1);
      end
      default: begin
        final_s  = 1'b0;
        strobe_s = 8'b0000_0000;
      end
    endcase
  end

  // Sequencer state, latched instruction and registered DataPath controls.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state_r            <= ST_IDLE;
      op_r               <= 3'b000;
      imm_r              <= {IMM_W{1'b0}};
      final_r            <= 1'b0;
      {RAin, RBin, RZin, RAout, RBout, RZout, done, illegal} <= 8'b0000_0000;
      AddImmediate       <= {IMM_W{1'b0}};
      RegisterAImmediate <= {IMM_W{1'b0}};
      busy               <= 1'b0;
    end else begin
      state_r            <= state_s;
      op_r               <= op_s;
      imm_r              <= imm_s;
      final_r            <= final_s;
      {RAin, RBin, RZin, RAout, RBout, RZout, done, illegal} <= strobe_s;
      AddImmediate       <= add_imm_s;
      RegisterAImmediate <= rega_imm_s;
      busy               <= (state_s != ST_IDLE);
    end
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      retired_count <= {CNT_W{1'b0}};
    end else if (retire_s) begin
      retired_count <= retired_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      retired_count <= retired_count;
    end
  end

  control_sequencer_checker #(.IMM_W(IMM_W)) u_checker (
    .clock              (clock),
    .clear              (clear),
    .RAin               (RAin),
    .RBin               (RBin),
    .RZin               (RZin),
    .RAout              (RAout),
    .RBout              (RBout),
    .RZout              (RZout),
    .busy               (busy),
    .done               (done),
    .illegal            (illegal),
    .AddImmediate       (AddImmediate),
    .RegisterAImmediate (RegisterAImmediate)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: a queue of expected steps per
// instruction is compared cycle by cycle against the DUT outputs.

module tb_control_sequencer;

  localparam int IMM_W = 8;
  localparam int CNT_W = 16;

  logic             clock = 1'b0;
  logic             clear = 1'b1;
  logic             instr_valid = 1'b0;
  logic             instr_ready;
  logic [2:0]       instr_op = 3'b000;
  logic [IMM_W-1:0] instr_imm = 8'h00;
  logic             RAin, RBin, RZin, RAout, RBout, RZout;
  logic [IMM_W-1:0] AddImmediate, RegisterAImmediate;
  logic             busy, done, illegal;
  logic [CNT_W-1:0] retired_count;

  int checks = 0;
  int errors = 0;

  // Model: each queued entry is one step; bit 25 marks "retires a legal instruction".
  logic [25:0] sq[$];
  logic [15:0] cnt_m;
  logic [25:0] exp_s;
  logic [25:0] obs_s;

  assign obs_s = {instr_ready, busy, done, illegal, RAin, RBin, RZin, RAout, RBout, RZout,
                  AddImmediate, RegisterAImmediate};

  always #5 clock = ~clock;

  control_sequencer #(.IMM_W(IMM_W), .CNT_W(CNT_W)) dut (
    .clock              (clock),
    .clear              (clear),
    .instr_valid        (instr_valid),
    .instr_ready        (instr_ready),
    .instr_op           (instr_op),
    .instr_imm          (instr_imm),
    .RAin               (RAin),
    .RBin               (RBin),
    .RZin               (RZin),
    .RAout              (RAout),
    .RBout              (RBout),
    .RZout              (RZout),
    .AddImmediate       (AddImmediate),
    .RegisterAImmediate (RegisterAImmediate),
    .busy               (busy),
    .done               (done),
    .illegal            (illegal),
    .retired_count      (retired_count)
  );

  function automatic logic [25:0] mk(input logic retire, input logic dn, input logic il,
                                     input logic [5:0] strb, input logic [7:0] add,
                                     input logic [7:0] rega);
    return {retire, 1'b1, dn, il, strb, add, rega};
  endfunction

  // Strobe field order: RAin RBin RZin RAout RBout RZout.
  task automatic push_instr(input logic [2:0] op, input logic [7:0] imm);
    case (op)
      3'd0: sq.push_back(mk(1'b1, 1'b1, 1'b0, 6'b000000, 8'h00, 8'h00));
      3'd1: sq.push_back(mk(1'b1, 1'b1, 1'b0, 6'b100000, 8'h00, imm));
      3'd2: begin
        sq.push_back(mk(1'b0, 1'b0, 1'b0, 6'b001100, imm, 8'h00));
        sq.push_back(mk(1'b1, 1'b1, 1'b0, 6'b010001, 8'h00, 8'h00));
      end
      3'd3: begin
        sq.push_back(mk(1'b0, 1'b0, 1'b0, 6'b001100, imm, 8'h00));
        sq.push_back(mk(1'b1, 1'b1, 1'b0, 6'b100001, 8'h00, 8'h00));
      end
      3'd4: sq.push_back(mk(1'b1, 1'b1, 1'b0, 6'b010001, 8'h00, 8'h00));
      3'd5: sq.push_back(mk(1'b1, 1'b1, 1'b0, 6'b100001, 8'h00, 8'h00));
      default: sq.push_back(mk(1'b0, 1'b0, 1'b1, 6'b000000, 8'h00, 8'h00));
    endcase
  endtask

  function automatic logic [25:0] model_exp();
    if (sq.size() == 0) return {1'b1, 25'd0};
    return {(sq.size() == 1) ? 1'b1 : 1'b0, sq[0][24:0]};
  endfunction

  task automatic model_reset();
    sq.delete();
    cnt_m = 16'h0000;
  endtask

  // Advance one clock: model consumes the current step and accepts if ready.
  task automatic tick();
    logic ready_m;
    @(posedge clock);
    if (clear) begin
      model_reset();
    end else begin
      ready_m = (sq.size() <= 1);
      if (sq.size() > 0) begin
        if (sq[0][25]) cnt_m = cnt_m + 16'h0001;
        void'(sq.pop_front());
      end
      if (instr_valid && ready_m) push_instr(instr_op, instr_imm);
    end
    @(negedge clock);
    exp_s = model_exp();
  endtask

  task automatic test_reset();
    instr_valid = 1'b1;
    instr_op    = 3'd1;
    instr_imm   = 8'h33;
    clear       = 1'b1;
    model_reset();
    @(negedge clock);
    @(negedge clock);
    checks++;
    if (obs_s !== {1'b1, 25'd0}) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected %h", obs_s, {1'b1, 25'd0});
    end
    checks++;
    if (retired_count !== 16'h0000) begin
      errors++;
      $display("FAIL reset_count: got %h expected 0000", retired_count);
    end
    instr_valid = 1'b0;
    clear       = 1'b0;
    tick();
    checks++;
    if (obs_s !== exp_s) begin
      errors++;
      $display("FAIL reset_release_idle: got %h expected %h", obs_s, exp_s);
    end
  endtask

  task automatic test_ldia();
    instr_valid = 1'b1;
    instr_op    = 3'd1;
    instr_imm   = 8'h05;
    tick();
    instr_valid = 1'b0;
    checks++;
    if (obs_s !== exp_s) begin
      errors++;
      $display("FAIL ldia_step: got %h expected %h", obs_s, exp_s);
    end
    checks++;
    if ({RAin, RegisterAImmediate, done, busy} !== {1'b1, 8'h05, 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL ldia_fields: got %b_%h_%b_%b expected 1_05_1_1",
               RAin, RegisterAImmediate, done, busy);
    end
    tick();
    checks++;
    if (obs_s !== exp_s || retired_count !== cnt_m) begin
      errors++;
      $display("FAIL ldia_after: got %h cnt %h expected %h cnt %h", obs_s, retired_count, exp_s, cnt_m);
    end
  endtask

  task automatic test_back_to_back();
    instr_valid = 1'b1;
    instr_op    = 3'd2;
    instr_imm   = 8'h05;
    tick();
    instr_op  = 3'd5;
    instr_imm = 8'($urandom);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs_s !== exp_s) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got %h expected %h", i, obs_s, exp_s);
      end
      if (i == 1) begin
        checks++;
        if ({RZout, RBin, done, instr_ready} !== 4'b1111) begin
          errors++;
          $display("FAIL b2b_addib_t1: got %b expected 1111", {RZout, RBin, done, instr_ready});
        end
      end
      if (i == 2) instr_valid = 1'b0;
      tick();
    end
    checks++;
    if (retired_count !== cnt_m) begin
      errors++;
      $display("FAIL b2b_count: got %h expected %h", retired_count, cnt_m);
    end
  endtask

  task automatic test_backpressure();
    int t0_cycles;
    t0_cycles   = 0;
    instr_valid = 1'b1;
    instr_op    = 3'd3;
    for (int i = 0; i < 6; i++) begin
      instr_imm = 8'($urandom);
      tick();
      if (RAout) t0_cycles++;
      checks++;
      if (obs_s !== exp_s) begin
        errors++;
        $display("FAIL bp_cycle%0d: got %h expected %h", i, obs_s, exp_s);
      end
    end
    instr_valid = 1'b0;
    checks++;
    if (t0_cycles !== 3) begin
      errors++;
      $display("FAIL bp_rate: got %0d T0 steps expected 3", t0_cycles);
    end
    tick();
    tick();
    checks++;
    if (obs_s !== exp_s || retired_count !== cnt_m) begin
      errors++;
      $display("FAIL bp_drain: got %h cnt %h expected %h cnt %h", obs_s, retired_count, exp_s, cnt_m);
    end
  endtask

  task automatic test_illegal();
    for (int k = 6; k < 8; k++) begin
      instr_valid = 1'b1;
      instr_op    = 3'(k);
      instr_imm   = 8'($urandom);
      tick();
      instr_valid = 1'b0;
      checks++;
      if (obs_s !== exp_s || {illegal, done} !== 2'b10) begin
        errors++;
        $display("FAIL illegal_op%0d: got %h expected %h", k, obs_s, exp_s);
      end
      tick();
      checks++;
      if (retired_count !== cnt_m) begin
        errors++;
        $display("FAIL illegal_count%0d: got %h expected %h", k, retired_count, cnt_m);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      instr_valid = ($urandom_range(0, 9) < 7);
      instr_op    = 3'($urandom_range(0, 7));
      instr_imm   = 8'($urandom);
      tick();
      checks++;
      if (obs_s !== exp_s || retired_count !== cnt_m) begin
        errors++;
        $display("FAIL random_cycle%0d: got %h cnt %h expected %h cnt %h",
                 i, obs_s, retired_count, exp_s, cnt_m);
      end
    end
    instr_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_mid_reset();
    instr_valid = 1'b1;
    instr_op    = 3'd2;
    instr_imm   = 8'hA5;
    tick();
    instr_valid = 1'b0;
    checks++;
    if (obs_s !== exp_s) begin
      errors++;
      $display("FAIL midrst_t0: got %h expected %h", obs_s, exp_s);
    end
    #2 clear = 1'b1;
    #1;
    checks++;
    if (obs_s !== {1'b1, 25'd0} || retired_count !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_async: got %h cnt %h expected %h cnt 0000", obs_s, retired_count, {1'b1, 25'd0});
    end
    @(negedge clock);
    clear = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs_s !== exp_s) begin
        errors++;
        $display("FAIL midrst_idle%0d: got %h expected %h", i, obs_s, exp_s);
      end
    end
  endtask

  task automatic test_wrap();
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    model_reset();
    instr_valid = 1'b1;
    instr_op    = 3'd0;
    for (int i = 0; i < 65536; i++) tick();
    checks++;
    if (retired_count !== 16'hFFFF || retired_count !== cnt_m) begin
      errors++;
      $display("FAIL wrap_preload: got %h expected ffff", retired_count);
    end
    instr_valid = 1'b0;
    tick();
    checks++;
    if (retired_count !== 16'h0000 || retired_count !== cnt_m) begin
      errors++;
      $display("FAIL wrap_zero: got %h expected 0000", retired_count);
    end
  endtask

  initial begin
    test_reset();
    test_ldia();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_random();
    test_mid_reset();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
